lfsr_sampler: RTL

//  Controller and output buffer for the N-bit LFSR. Drives the LFSR seed-load inputs and

---
 rtl/lfsr_sampler.sv | 87 ++++++++
 1 files changed

// File: rtl/lfsr_sampler.sv
// lfsr_sampler: seeds an external LFSR, waits out a warm-up period, then buffers every DECIM-th state word into a FIFO
// Ports: clk, r_n (async active-low reset), start/stop pulses, q_in (LFSR state word),
//   load/seed_out/lfsr_r (drive the LFSR), out_data/out_valid/out_ready (downstream handshake),
//   overflow (sticky drop flag), reseeds (saturating lock-up count), busy (not idle)
module lfsr_sampler #(
  parameter int N = 26,
  parameter int DEPTH = 4,
  parameter int DECIM = 26,
  parameter int WARMUP = 26,
  parameter logic [3:0] SEED = 4'b0001
) (
  input  logic         clk,
  input  logic         r_n,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] q_in,
  output logic         load,
  output logic [3:0]   seed_out,
  output logic         lfsr_r,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow,
  output logic [7:0]   reseeds,
  output logic         busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int WW = WARMUP > 1 ? $clog2(WARMUP) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SEED, S_WARM, S_RUN} state_t;
  state_t state, state_n;
  logic [WW-1:0] warm_cnt;
  logic [DW-1:0] dec_cnt;
  logic [N-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0] count, count_n;
  logic warm_done, dec_done, lock, due, full, pop, push, drop;
  assign lfsr_r = ~r_n;
  assign load = state == S_SEED;
  assign seed_out = load ? SEED : 4'b0;
  assign busy = state != S_IDLE;
  assign out_valid = count != '0;
  always_ff @(posedge clk or negedge r_n)
    if (!r_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    warm_done = warm_cnt == WW'(WARMUP - 1);
    dec_done = dec_cnt == DW'(DECIM - 1);
    lock = state == S_RUN && q_in == '0;
    due = state == S_RUN && !lock && !stop && dec_done;
    state_n = stop ? S_IDLE :
              (state == S_IDLE && start) ? S_SEED :
              state == S_SEED ? S_WARM :
              (state == S_WARM && warm_done) ? S_RUN :
              lock ? S_SEED : state;
    full = count == CW'(DEPTH);
    pop = out_valid && out_ready;
    push = due && (!full || pop);
    drop = due && full && !pop;
    rd_n = rd_ptr + PW'(pop);
    count_n = count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= q_in;
  always_ff @(posedge clk or negedge r_n)
    if (!r_n) begin
      warm_cnt <= '0;
      dec_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      reseeds <= '0;
    end else begin
      warm_cnt <= state == S_SEED ? '0 : state == S_WARM ? warm_cnt + 1'b1 : warm_cnt;
      dec_cnt <= (state != S_RUN || dec_done) ? '0 : dec_cnt + 1'b1;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_n;
      count <= count_n;
      overflow <= overflow | drop;
      reseeds <= reseeds + 8'(lock && !stop && reseeds != 8'hff);
      // when the FIFO is empty after this pop, the new head is the word being pushed now
      if (count_n != '0) out_data <= count == CW'(pop) ? q_in : mem[rd_n];
    end
endmodule
